// File: rtl/mmio_pkg.sv
// mmio_pkg
// Shared constants for the memory-mapped port unit: the default window base,
// register offsets inside the window, and STATUS bit positions.
// Optional feature macro: MMIO_PORT_IRQ_EN (adds the IRQ_MASK register at 0x14
// and moves the top of the decode window up to that offset).
package mmio_pkg;

   localparam logic [31:0] BASE_ADDR_DEFAULT = 32'h1001_0040;

   localparam logic [4:0] OFF_PORT_OUT    = 5'h00;
   localparam logic [4:0] OFF_PORT_IN     = 5'h04;
   localparam logic [4:0] OFF_STATUS      = 5'h08;
   localparam logic [4:0] OFF_TIMER_CMP   = 5'h0C;
   localparam logic [4:0] OFF_TIMER_COUNT = 5'h10;
   localparam logic [4:0] OFF_IRQ_MASK    = 5'h14;

   // Highest offset that still decodes as a hit
`ifdef MMIO_PORT_IRQ_EN
   localparam logic [4:0] OFF_LAST = OFF_IRQ_MASK;
`else
   localparam logic [4:0] OFF_LAST = OFF_TIMER_COUNT;
`endif

   localparam int ST_IN_CHG    = 0;
   localparam int ST_TMR_MATCH = 1;

endpackage

// File: rtl/mmio_port_unit_input_sync_edge.sv
// input_sync_edge
// Two-flop synchronizer for an asynchronous input bus followed by a
// previous-sample register, giving a synchronized value and a one-cycle
// "value differs from last cycle" flag.
// Ports:
//   clk       rising-edge clock
//   reset     asynchronous active-high reset (all stages clear to 0)
//   async_in  asynchronous external input
//   sync_out  synchronized value (second flop)
//   changed   high while the synchronized value differs from the previous sample
module input_sync_edge #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [WIDTH-1:0] async_in,
   output logic [WIDTH-1:0] sync_out,
   output logic             changed
);

   logic [WIDTH-1:0] stage1;
   logic [WIDTH-1:0] stage2;
   logic [WIDTH-1:0] prev;

   // stage1/stage2 form the metastability chain; prev holds the last
   // synchronized value so a change can be detected one edge later
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         stage1 <= '0;
         stage2 <= '0;
         prev   <= '0;
      end else begin
         stage1 <= async_in;
         stage2 <= stage1;
         prev   <= stage2;
      end
   end

   assign sync_out = stage2;
   assign changed  = (stage2 != prev);

endmodule

// File: rtl/mmio_port_unit.sv
// mmio_port_unit
// Memory-mapped I/O responder sharing the data-RAM bus. Drives a 32-bit output
// port, samples an asynchronous input port, latches input-change and timer
// match events in a write-1-to-clear STATUS register, and runs a programmable
// cycle timer.
// Ports:
//   clk        rising-edge clock
//   reset      asynchronous active-high reset
//   Address    byte address from the ALU
//   WriteData  store data
//   MemWrite   store strobe
//   MemRead    load strobe
//   PortIn     asynchronous external input
//   ReadData   combinational load data, 0 when not selected
//   IOSelect   combinational window hit, used to steer load data away from RAM
//   PortOut    registered output port
//   IRQ        registered interrupt (only with MMIO_PORT_IRQ_EN)
// Optional feature macro: MMIO_PORT_IRQ_EN.
module mmio_port_unit
   import mmio_pkg::*;
#(
   parameter logic [31:0] BASE_ADDR  = BASE_ADDR_DEFAULT,
   parameter int          DATA_WIDTH = 32,
   parameter int          IN_WIDTH   = 8
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [31:0]           Address,
   input  logic [DATA_WIDTH-1:0] WriteData,
   input  logic                  MemWrite,
   input  logic                  MemRead,
   input  logic [IN_WIDTH-1:0]   PortIn,
   output logic [DATA_WIDTH-1:0] ReadData,
   output logic                  IOSelect,
   output logic [DATA_WIDTH-1:0] PortOut
`ifdef MMIO_PORT_IRQ_EN
   ,
   output logic                  IRQ
`endif
);

   logic [4:0]            offset;
   logic                  hit;
   logic                  wr_en;
   logic                  rd_en;
   logic                  wr_port_out;
   logic                  wr_status;
   logic                  wr_timer_cmp;
   logic                  wr_timer_count;
   logic [IN_WIDTH-1:0]   port_in_sync;
   logic                  in_changed;
   logic [DATA_WIDTH-1:0] timer_cmp;
   logic [DATA_WIDTH-1:0] timer_count;
   logic                  timer_match;
   logic [1:0]            status;
   logic [1:0]            status_next;

   // The window base is 32-byte aligned, so the upper bits select the window
   // and the low five bits are the register offset within it
   assign offset = Address[4:0];
   assign hit    = (Address[31:5] == BASE_ADDR[31:5]) &&
                   (Address[1:0] == 2'b00) &&
                   (offset <= OFF_LAST);

   assign IOSelect       = hit;
   assign wr_en          = MemWrite & hit;
   assign rd_en          = MemRead & hit;
   assign wr_port_out    = wr_en && (offset == OFF_PORT_OUT);
   assign wr_status      = wr_en && (offset == OFF_STATUS);
   assign wr_timer_cmp   = wr_en && (offset == OFF_TIMER_CMP);
   assign wr_timer_count = wr_en && (offset == OFF_TIMER_COUNT);

   input_sync_edge #(
      .WIDTH (IN_WIDTH)
   ) u_input_sync (
      .clk      (clk),
      .reset    (reset),
      .async_in (PortIn),
      .sync_out (port_in_sync),
      .changed  (in_changed)
   );

   // Output port and compare register are plain RW registers
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         PortOut   <= '0;
         timer_cmp <= '0;
      end else begin
         if (wr_port_out) begin
            PortOut <= WriteData;
         end
         if (wr_timer_cmp) begin
            timer_cmp <= WriteData;
         end
      end
   end

   // A match is only a real wrap when software is not clearing the count in
   // the same cycle; the software clear takes priority
   assign timer_match = (timer_cmp != '0) && (timer_count == timer_cmp) && !wr_timer_count;

   // Timer holds while the compare value is zero; a new compare below the
   // current count is only reached after the counter rolls over
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         timer_count <= '0;
      end else if (wr_timer_count) begin
         timer_count <= '0;
      end else if (timer_cmp != '0) begin
         if (timer_match) begin
            timer_count <= '0;
         end else begin
            timer_count <= timer_count + DATA_WIDTH'(1);
         end
      end
   end

   // Write-1-to-clear is applied first and hardware sets are ORed in last,
   // so an event arriving with a clear of the same bit survives
   always_comb begin
      status_next = status;
      if (wr_status) begin
         status_next = status & ~WriteData[1:0];
      end
      if (in_changed) begin
         status_next[ST_IN_CHG] = 1'b1;
      end
      if (timer_match) begin
         status_next[ST_TMR_MATCH] = 1'b1;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         status <= '0;
      end else begin
         status <= status_next;
      end
   end

`ifdef MMIO_PORT_IRQ_EN
   logic [1:0] irq_mask;
   logic       wr_irq_mask;

   assign wr_irq_mask = wr_en && (offset == OFF_IRQ_MASK);

   // IRQ is registered from the current STATUS, so it follows a status set
   // by one cycle and drops one cycle after the bit is cleared
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         irq_mask <= '0;
         IRQ      <= 1'b0;
      end else begin
         if (wr_irq_mask) begin
            irq_mask <= WriteData[1:0];
         end
         IRQ <= |(status & irq_mask);
      end
   end
`endif

   // Load data is combinational from the current register values, so a
   // simultaneous store is not visible until after the edge
   always_comb begin
      ReadData = '0;
      if (rd_en) begin
         case (offset)
            OFF_PORT_OUT:    ReadData = PortOut;
            OFF_PORT_IN:     ReadData = {{(DATA_WIDTH-IN_WIDTH){1'b0}}, port_in_sync};
            OFF_STATUS:      ReadData = {{(DATA_WIDTH-2){1'b0}}, status};
            OFF_TIMER_CMP:   ReadData = timer_cmp;
            OFF_TIMER_COUNT: ReadData = timer_count;
`ifdef MMIO_PORT_IRQ_EN
            OFF_IRQ_MASK:    ReadData = {{(DATA_WIDTH-2){1'b0}}, irq_mask};
`endif
            default:         ReadData = '0;
         endcase
      end
   end

endmodule

// File: tb/tb_mmio_port_unit.sv
// tb_mmio_port_unit
// Self-checking bench for mmio_port_unit: directed table of loads across the
// register window, hand sequences for the timer, input path and reset, and a
// randomized run against a register-level reference model.
// Optional feature macro: MMIO_PORT_IRQ_EN (bench connects and checks IRQ).
module tb_mmio_port_unit;

   localparam logic [31:0] BASE = 32'h1001_0040;
`ifdef MMIO_PORT_IRQ_EN
   localparam logic [31:0] LAST_OFF = 32'h14;
   localparam logic        SEL54 = 1'b1;
`else
   localparam logic [31:0] LAST_OFF = 32'h10;
   localparam logic        SEL54 = 1'b0;
`endif

   logic        clk;
   logic        reset;
   logic [31:0] Address;
   logic [31:0] WriteData;
   logic        MemWrite;
   logic        MemRead;
   logic [7:0]  PortIn;
   logic [31:0] ReadData;
   logic        IOSelect;
   logic [31:0] PortOut;
   logic        IRQ;

   int testsRun;
   int testsFailed;

   mmio_port_unit dut (
      .clk       (clk),
      .reset     (reset),
      .Address   (Address),
      .WriteData (WriteData),
      .MemWrite  (MemWrite),
      .MemRead   (MemRead),
      .PortIn    (PortIn),
      .ReadData  (ReadData),
      .IOSelect  (IOSelect),
      .PortOut   (PortOut)
`ifdef MMIO_PORT_IRQ_EN
      ,
      .IRQ       (IRQ)
`endif
   );

`ifndef MMIO_PORT_IRQ_EN
   assign IRQ = 1'b0;
`endif

   // Free-running clock, rising edges at 5, 15, 25 ...
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   typedef struct {
      logic [31:0] addr;
      logic        re;
      logic [31:0] expRead;
      logic        expSel;
   } vec_t;

   vec_t vecs [0:11];

   // Reference model state, kept at register level
   logic [31:0] mOut;
   logic [31:0] mCmp;
   logic [31:0] mCount;
   logic [1:0]  mStatus;
   logic [1:0]  mMask;
   logic        mIrq;
   logic [7:0]  hist [0:2];

   logic [31:0] offTab [0:10];
   logic [31:0] rAddr;
   logic [31:0] rData;
   logic        rWe;
   logic        rRe;
   logic [31:0] expRd;
   logic        found;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic applyStimulus(input logic [31:0] a, input logic we, input logic re,
                                input logic [31:0] d);
      Address   = a;
      MemWrite  = we;
      MemRead   = re;
      WriteData = d;
      #1;
   endtask

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      testsRun++;
      if (act !== exp) begin
         testsFailed++;
         $display("[TB] FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic doReset();
      reset = 1'b1;
      #3;
      reset = 1'b0;
   endtask

   function automatic logic modelHit(input logic [31:0] a);
      return (a >= BASE) && (a <= BASE + LAST_OFF) && (a % 4 == 0);
   endfunction

   function automatic logic [31:0] modelRead(input logic [31:0] a);
      logic [31:0] o;
      if (!modelHit(a)) return 32'h0;
      o = a - BASE;
      case (o)
         32'h00:  return mOut;
         32'h04:  return {24'h0, hist[1]};
         32'h08:  return {30'h0, mStatus};
         32'h0C:  return mCmp;
         32'h10:  return mCount;
         32'h14:  return {30'h0, mMask};
         default: return 32'h0;
      endcase
   endfunction

   // Advance the model across one clock edge given this cycle's bus inputs
   task automatic modelEdge(input logic [31:0] a, input logic we, input logic [31:0] d);
      logic        w;
      logic [31:0] o;
      logic        clrCount;
      logic        match;
      logic        chg;
      logic [1:0]  st;
      w        = we && modelHit(a);
      o        = a - BASE;
      clrCount = w && (o == 32'h10);
      match    = (mCmp != 0) && (mCount == mCmp) && !clrCount;
      chg      = (hist[1] != hist[2]);
      mIrq     = |(mStatus & mMask);
      st       = mStatus;
      if (w && o == 32'h08) st = st & ~d[1:0];
      if (chg) st[0] = 1'b1;
      if (match) st[1] = 1'b1;
      mStatus = st;
      if (clrCount) mCount = 0;
      else if (mCmp != 0) mCount = match ? 32'h0 : mCount + 1;
      if (w && o == 32'h00) mOut = d;
      if (w && o == 32'h0C) mCmp = d;
      if (w && o == 32'h14) mMask = d[1:0];
      hist[2] = hist[1];
      hist[1] = hist[0];
      hist[0] = PortIn;
   endtask

   initial begin
      testsRun    = 0;
      testsFailed = 0;
      reset       = 1'b1;
      Address     = 32'h0;
      WriteData   = 32'h0;
      MemWrite    = 1'b0;
      MemRead     = 1'b0;
      PortIn      = 8'h00;

      // Reset state
      #12;
      checkOutput("reset_portout", PortOut, 32'h0);
      checkOutput("reset_irq", {31'h0, IRQ}, 32'h0);
      reset = 1'b0;
      tick();

      // Store with a simultaneous load: load sees the pre-write value
      applyStimulus(32'h1001_0040, 1'b1, 1'b1, 32'hDEADBEEF);
      checkOutput("rw_same_cycle_read", ReadData, 32'h0);
      checkOutput("rw_same_cycle_sel", {31'h0, IOSelect}, 32'h1);
      tick();
      checkOutput("store_portout", PortOut, 32'hDEADBEEF);

      vecs[0]  = '{32'h1001_0040, 1'b1, 32'hDEADBEEF, 1'b1};
      vecs[1]  = '{32'h1001_0044, 1'b1, 32'h0, 1'b1};
      vecs[2]  = '{32'h1001_0048, 1'b1, 32'h0, 1'b1};
      vecs[3]  = '{32'h1001_004C, 1'b1, 32'h0, 1'b1};
      vecs[4]  = '{32'h1001_0050, 1'b1, 32'h0, 1'b1};
      vecs[5]  = '{32'h1001_0054, 1'b1, 32'h0, SEL54};
      vecs[6]  = '{32'h1001_0042, 1'b1, 32'h0, 1'b0};
      vecs[7]  = '{32'h1001_0060, 1'b1, 32'h0, 1'b0};
      vecs[8]  = '{32'h1001_0040, 1'b0, 32'h0, 1'b1};
      vecs[9]  = '{32'h1001_0041, 1'b1, 32'h0, 1'b0};
      vecs[10] = '{32'h0001_0040, 1'b1, 32'h0, 1'b0};
      vecs[11] = '{32'h1001_003C, 1'b1, 32'h0, 1'b0};
      for (int i = 0; i < 12; i++) begin
         applyStimulus(vecs[i].addr, 1'b0, vecs[i].re, 32'h0);
         checkOutput($sformatf("table_read_%0d", i), ReadData, vecs[i].expRead);
         checkOutput($sformatf("table_sel_%0d", i), {31'h0, IOSelect}, {31'h0, vecs[i].expSel});
         tick();
      end

      // Stores outside the window must not land anywhere
      applyStimulus(32'h1001_0042, 1'b1, 1'b0, 32'h1111_1111);
      tick();
      applyStimulus(32'h1001_0060, 1'b1, 1'b0, 32'h2222_2222);
      tick();
      applyStimulus(32'h1001_0040, 1'b0, 1'b1, 32'h0);
      checkOutput("no_stray_write_portout", PortOut, 32'hDEADBEEF);
      checkOutput("no_stray_write_read", ReadData, 32'hDEADBEEF);

      // Timer: cmp=5 gives 0 then 1..5, wraps to 0 with TMR_MATCH set;
      // a W1C issued in the count==5 cycle loses to the set
      doReset();
      applyStimulus(32'h1001_004C, 1'b1, 1'b0, 32'd5);
      tick();
      for (int k = 0; k <= 5; k++) begin
         applyStimulus(32'h1001_0050, 1'b0, 1'b1, 32'h0);
         checkOutput($sformatf("timer_count_%0d", k), ReadData, k);
         if (k < 5) tick();
      end
      applyStimulus(32'h1001_0048, 1'b1, 1'b0, 32'h2);
      tick();
      applyStimulus(32'h1001_0048, 1'b0, 1'b1, 32'h0);
      checkOutput("match_set_wins_w1c", ReadData, 32'h2);
      tick();
      applyStimulus(32'h1001_0050, 1'b0, 1'b1, 32'h0);
      checkOutput("timer_after_wrap", ReadData, 32'h1);
      applyStimulus(32'h1001_0048, 1'b1, 1'b0, 32'h2);
      tick();
      applyStimulus(32'h1001_0048, 1'b0, 1'b1, 32'h0);
      checkOutput("status_w1c_match", ReadData, 32'h0);

      // Input path: visible after 2 edges, IN_CHG after the 3rd
      doReset();
      PortIn = 8'hA5;
      applyStimulus(32'h1001_0044, 1'b0, 1'b1, 32'h0);
      checkOutput("portin_edge0", ReadData, 32'h0);
      tick();
      checkOutput("portin_edge1", ReadData, 32'h0);
      tick();
      checkOutput("portin_edge2", ReadData, 32'hA5);
      applyStimulus(32'h1001_0048, 1'b0, 1'b1, 32'h0);
      checkOutput("inchg_edge2", ReadData, 32'h0);
      tick();
      checkOutput("inchg_edge3", ReadData, 32'h1);
      applyStimulus(32'h1001_0048, 1'b1, 1'b0, 32'h1);
      tick();
      applyStimulus(32'h1001_0048, 1'b0, 1'b1, 32'h0);
      checkOutput("inchg_w1c", ReadData, 32'h0);

      // Asynchronous reset in the middle of counting
      PortIn = 8'h00;
      doReset();
      applyStimulus(32'h1001_0040, 1'b1, 1'b0, 32'h1234);
      tick();
      applyStimulus(32'h1001_004C, 1'b1, 1'b0, 32'd10);
      tick();
      tick();
      tick();
      tick();
      applyStimulus(32'h1001_0050, 1'b0, 1'b1, 32'h0);
      checkOutput("midreset_pre_count", ReadData, 32'h3);
      checkOutput("midreset_pre_portout", PortOut, 32'h1234);
      #1;
      reset = 1'b1;
      #1;
      checkOutput("midreset_portout", PortOut, 32'h0);
      checkOutput("midreset_count", ReadData, 32'h0);
      reset = 1'b0;
      applyStimulus(32'h1001_004C, 1'b0, 1'b1, 32'h0);
      checkOutput("midreset_cmp", ReadData, 32'h0);
      tick();

`ifdef MMIO_PORT_IRQ_EN
      // IRQ follows TMR_MATCH by one cycle and drops after a W1C
      doReset();
      applyStimulus(32'h1001_0054, 1'b1, 1'b0, 32'h2);
      tick();
      applyStimulus(32'h1001_004C, 1'b1, 1'b0, 32'd3);
      tick();
      found = 1'b0;
      for (int k = 0; k < 20 && !found; k++) begin
         applyStimulus(32'h1001_0048, 1'b0, 1'b1, 32'h0);
         if (ReadData[1]) found = 1'b1;
         else tick();
      end
      checkOutput("irq_match_seen", {31'h0, found}, 32'h1);
      checkOutput("irq_low_on_set_cycle", {31'h0, IRQ}, 32'h0);
      applyStimulus(32'h1001_004C, 1'b1, 1'b0, 32'h0);
      tick();
      checkOutput("irq_high", {31'h0, IRQ}, 32'h1);
      applyStimulus(32'h1001_0048, 1'b1, 1'b0, 32'h2);
      tick();
      applyStimulus(32'h1001_0040, 1'b0, 1'b0, 32'h0);
      tick();
      checkOutput("irq_low_after_w1c", {31'h0, IRQ}, 32'h0);
`endif

      // Randomized run against the reference model
      offTab = '{32'h00, 32'h04, 32'h08, 32'h0C, 32'h10, 32'h14, 32'h18,
                 32'h02, 32'h01, 32'h20, 32'h3C};
      PortIn = 8'h00;
      applyStimulus(32'h0, 1'b0, 1'b0, 32'h0);
      doReset();
      mOut = 0; mCmp = 0; mCount = 0; mStatus = 0; mMask = 0; mIrq = 0;
      hist[0] = 0; hist[1] = 0; hist[2] = 0;
      for (int cyc = 0; cyc < 400; cyc++) begin
         rAddr = BASE + offTab[$urandom_range(0, 10)];
         rWe   = ($urandom_range(0, 2) == 0);
         rRe   = ($urandom_range(0, 1) == 1);
         case (rAddr - BASE)
            32'h08:  rData = {30'h0, 2'($urandom_range(0, 3))};
            32'h0C:  rData = $urandom_range(0, 12);
            default: rData = $urandom;
         endcase
         if ($urandom_range(0, 3) == 0) PortIn = 8'($urandom);
         applyStimulus(rAddr, rWe, rRe, rData);
         expRd = rRe ? modelRead(rAddr) : 32'h0;
         checkOutput("rand_read", ReadData, expRd);
         checkOutput("rand_sel", {31'h0, IOSelect}, {31'h0, modelHit(rAddr)});
         modelEdge(rAddr, rWe, rData);
         tick();
         checkOutput("rand_portout", PortOut, mOut);
`ifdef MMIO_PORT_IRQ_EN
         checkOutput("rand_irq", {31'h0, IRQ}, {31'h0, mIrq});
`endif
      end

      $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
      $finish;
   end

endmodule
